// File: rtl/en_latch_pkg.sv
// Shared types and helpers for the gated SR latch.
// The operation enum names what one latch cell does on a clock edge.
// decode_op folds the gate and the set/reset pair into one of those operations.
// The cell state enum records whether a cell holds 0, holds 1, or is in the forbidden 0/0 condition.
package en_latch_pkg;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_SET,
    OP_RESET,
    OP_ILLEGAL
  } latch_op_e;

  typedef enum logic [1:0] {
    CELL_CLEAR,
    CELL_SET,
    CELL_FORBID
  } cell_state_e;

  localparam logic Q_RST    = 1'b0;
  localparam logic QBAR_RST = 1'b1;

  // Any request made while the gate is closed is treated as a hold.
  function automatic latch_op_e decode_op(input logic en, input logic s, input logic r);
    latch_op_e op;
    op = OP_HOLD;
    if (en) begin
      case ({s, r})
        2'b10:   op = OP_SET;
        2'b01:   op = OP_RESET;
        2'b11:   op = OP_ILLEGAL;
        default: op = OP_HOLD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/en_latch_bit.sv
// One bit of the gated SR latch, modelled as clocked state.
// Optional macro EN_LATCH_ILLEGAL_DET_EN adds a registered flag that marks
// a forbidden set+reset request sampled on the previous edge.
module en_latch_bit
  import en_latch_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic s_i,
  input  logic r_i,
  output logic q_o,
  output logic qbar_o
`ifdef EN_LATCH_ILLEGAL_DET_EN
  ,
  output logic illegal_o
`endif
);

  latch_op_e   op;
  cell_state_e state_q, state_d;
  logic        q_q, q_d;
  logic        qbar_q, qbar_d;

  assign op = decode_op(en_i, s_i, r_i);

  // Next state: a hold after the forbidden 0/0 condition resolves to the reset value,
  // like a NOR latch where reset wins the race, so the outputs stay fully defined.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qbar_d  = qbar_q;
    case (op)
      OP_SET: begin
        state_d = CELL_SET;
        q_d     = 1'b1;
        qbar_d  = 1'b0;
      end
      OP_RESET: begin
        state_d = CELL_CLEAR;
        q_d     = 1'b0;
        qbar_d  = 1'b1;
      end
      OP_ILLEGAL: begin
        state_d = CELL_FORBID;
        q_d     = 1'b0;
        qbar_d  = 1'b0;
      end
      default: begin
        if (state_q == CELL_FORBID) begin
          state_d = CELL_CLEAR;
          q_d     = Q_RST;
          qbar_d  = QBAR_RST;
        end
      end
    endcase
  end

  // State and output registers; reset overrides the gate and both requests.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CELL_CLEAR;
      q_q     <= Q_RST;
      qbar_q  <= QBAR_RST;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qbar_q  <= qbar_d;
    end
  end

  assign q_o    = q_q;
  assign qbar_o = qbar_q;

`ifdef EN_LATCH_ILLEGAL_DET_EN
  logic illegal_q;

  // Flags each edge on which a forbidden request was sampled; cleared on the next clean edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= (op == OP_ILLEGAL);
    end
  end

  assign illegal_o = illegal_q;
`endif

endmodule

// File: rtl/en_latch.sv
// WIDTH-bit gated SR latch built from independent one-bit cells sharing one enable.
// Optional macro EN_LATCH_ILLEGAL_DET_EN adds per-bit illegal flags and a sticky
// illegal_seen summary that only reset clears.
module en_latch
  import en_latch_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
`ifdef EN_LATCH_ILLEGAL_DET_EN
  ,
  output logic [WIDTH-1:0] illegal,
  output logic             illegal_seen
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    en_latch_bit u_bit (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .en_i      (en),
      .s_i       (s[i]),
      .r_i       (r[i]),
      .q_o       (q[i]),
      .qbar_o    (qbar[i])
`ifdef EN_LATCH_ILLEGAL_DET_EN
      ,
      .illegal_o (illegal[i])
`endif
    );
  end

`ifdef EN_LATCH_ILLEGAL_DET_EN
  logic illegal_hit;
  logic illegal_seen_q, illegal_seen_d;

  // Detect a forbidden request on any bit this cycle, so the sticky flag rises on the same edge as the per-bit flag.
  always_comb begin
    illegal_hit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (decode_op(en, s[i], r[i]) == OP_ILLEGAL) begin
        illegal_hit = 1'b1;
      end
    end
    illegal_seen_d = illegal_seen_q | illegal_hit;
  end

  // Sticky summary register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign illegal_seen = illegal_seen_q;
`endif

endmodule

// File: tb/tb_en_latch.sv
// Scoreboard bench for en_latch at WIDTH=4: the driver pushes the expected
// post-edge outputs from a per-bit rule model, a monitor pops and compares after each edge.
module tb_en_latch;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] illegal;
    logic             seen;
    int               phase;
  } expect_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
`ifdef EN_LATCH_ILLEGAL_DET_EN
  logic [WIDTH-1:0] illegal;
  logic             illegal_seen;
`endif

  expect_t          scoreboard[$];
  int               checks = 0;
  int               errors = 0;

  logic [WIDTH-1:0] modelQ    = '0;
  logic [WIDTH-1:0] modelQbar = '1;
  logic             modelSeen = 1'b0;

  en_latch #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .s            (s),
    .r            (r),
    .q            (q),
    .qbar         (qbar)
`ifdef EN_LATCH_ILLEGAL_DET_EN
    ,
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string phaseName(input int p);
    case (p)
      1: return "reset";
      2: return "gated_hold";
      3: return "set_reset";
      4: return "forbidden";
      5: return "enable_edge";
      6: return "mixed_bits";
      default: return "random";
    endcase
  endfunction

  // Drive one cycle of inputs on the falling edge and queue what the latch must show after the next rising edge.
  task automatic applyStimulus(input logic rstnV, input logic enV,
                               input logic [WIDTH-1:0] sV, input logic [WIDTH-1:0] rV,
                               input int phase);
    expect_t e;
    logic [WIDTH-1:0] ill;
    @(negedge clk);
    rst_n = rstnV;
    en    = enV;
    s     = sV;
    r     = rV;
    ill   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!rstnV) begin
        modelQ[i] = 1'b0; modelQbar[i] = 1'b1;
      end else if (enV && sV[i] && rV[i]) begin
        modelQ[i] = 1'b0; modelQbar[i] = 1'b0; ill[i] = 1'b1;
      end else if (enV && sV[i]) begin
        modelQ[i] = 1'b1; modelQbar[i] = 1'b0;
      end else if (enV && rV[i]) begin
        modelQ[i] = 1'b0; modelQbar[i] = 1'b1;
      end else if (!modelQ[i] && !modelQbar[i]) begin
        modelQbar[i] = 1'b1;
      end
    end
    modelSeen = rstnV ? (modelSeen | (|ill)) : 1'b0;
    e.q       = modelQ;
    e.qbar    = modelQbar;
    e.illegal = ill;
    e.seen    = modelSeen;
    e.phase   = phase;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int phase,
                             input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s/%s got %b want %b at %0t", phaseName(phase), name, got, want, $time);
    end
  endtask

  // Monitor: outputs are valid one unit after every rising edge that follows a queued stimulus.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput("q", e.phase, q, e.q);
        checkOutput("qbar", e.phase, qbar, e.qbar);
`ifdef EN_LATCH_ILLEGAL_DET_EN
        checkOutput("illegal", e.phase, illegal, e.illegal);
        checkOutput("illegal_seen", e.phase, {{(WIDTH-1){1'b0}}, illegal_seen},
                    {{(WIDTH-1){1'b0}}, e.seen});
`endif
      end
    end
  end

  // Directed scenarios followed by randomized traffic, then drain the scoreboard and report.
  initial begin
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rr;
    int               waitCycles;
    rst_n = 1'b0;
    en    = 1'b0;
    s     = '0;
    r     = '0;

    applyStimulus(1'b0, 1'b1, '1, '0, 1);
    applyStimulus(1'b0, 1'b1, '1, '0, 1);
    applyStimulus(1'b1, 1'b1, '1, '0, 1);

    applyStimulus(1'b1, 1'b1, '0, '1, 2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? '1 : '0, ((i / 2) % 2 == 0) ? '1 : '0, 2);
    end

    applyStimulus(1'b1, 1'b1, '1, '0, 3);
    applyStimulus(1'b1, 1'b1, '0, '1, 3);
    applyStimulus(1'b1, 1'b1, '0, '0, 3);
    applyStimulus(1'b1, 1'b1, '0, '0, 3);

    applyStimulus(1'b1, 1'b1, '1, '0, 4);
    applyStimulus(1'b1, 1'b1, '1, '1, 4);
    applyStimulus(1'b1, 1'b1, '0, '0, 4);
    applyStimulus(1'b1, 1'b0, '1, '0, 4);
    applyStimulus(1'b1, 1'b1, '1, '0, 4);
    applyStimulus(1'b0, 1'b1, '1, '0, 4);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, ((i / 8) % 2) == 1, '1, '0, 5);
    end

    applyStimulus(1'b0, 1'b0, '0, '0, 6);
    applyStimulus(1'b1, 1'b1, 4'b1010, 4'b0110, 6);
    applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000, 6);

    for (int i = 0; i < 300; i++) begin
      rs = WIDTH'($urandom());
      rr = WIDTH'($urandom());
      applyStimulus($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)), rs, rr, 7);
    end

    waitCycles = 0;
    while (scoreboard.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (scoreboard.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain pending %0d want 0", scoreboard.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
